// File: rtl/ysyx_22041412_wb_arb_pkg.sv
// Purpose: shared widths, source IDs and helpers for the writeback arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN, NREG, REG_IDX_W, default starvation limit, src_e, idxOneHot().
package ysyx_22041412_wb_arb_pkg;

    localparam int XLEN           = 64;
    localparam int NREG           = 32;
    localparam int REG_IDX_W      = 5;
    localparam int STARVE_LIM_DEF = 4;

    typedef logic [REG_IDX_W-1:0] regIdx_t;
    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [NREG-1:0]      regVec_t;

    // Result source identifiers; SRC_NONE means no grant this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_MDU  = 2'd3
    } src_e;

    function automatic regVec_t idxOneHot(input regIdx_t idx);
        regVec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ysyx_22041412_wb_arb_if.sv
// Purpose: one execution-unit result channel (valid/ready + destination + data).
// Latency: n/a (wires only).
// Backpressure: producer holds valid/rd/data stable until ready is seen high.
// Modports: master = producing unit (drives valid/rd/data), slave = arbiter (drives ready).
interface ysyx_22041412_wb_arb_if;
    import ysyx_22041412_wb_arb_pkg::*;

    logic    valid;
    logic    ready;
    regIdx_t rd;
    xlen_t   data;

    modport master (output valid, output rd, output data, input ready);
    modport slave  (input valid, input rd, input data, output ready);

endinterface

// File: rtl/ysyx_22041412_wb_arb_scoreboard.sv
// Purpose: per-GPR pending-write bits with three combinational hazard queries.
// Latency: set/clear take effect at the clock edge; queries are combinational.
// Backpressure: none; decode must not issue a destination already busy.
// Ports: clk, rst; setVld/setIdx (issue), clrVld/clrIdx (GPR write cycle);
//        rs1Idx/rs2Idx/rdIdx -> rs1Busy/rs2Busy/rdBusy.
// Option WB_BYPASS_EN: rs1/rs2 queries ignore the register being written this cycle.
module ysyx_22041412_wb_arb_scoreboard
    import ysyx_22041412_wb_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    setVld,
    input  regIdx_t setIdx,
    input  logic    clrVld,
    input  regIdx_t clrIdx,
    input  regIdx_t rs1Idx,
    input  regIdx_t rs2Idx,
    input  regIdx_t rdIdx,
    output logic    rs1Busy,
    output logic    rs2Busy,
    output logic    rdBusy
);

    regVec_t busyVec;
    regVec_t busyNext;
    regVec_t setMask;
    regVec_t clrMask;

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (setVld && setIdx != '0) setMask = idxOneHot(setIdx);
        if (clrVld)                 clrMask = idxOneHot(clrIdx);
        // Set is applied after clear so a re-issue in the write cycle stays pending.
        busyNext    = (busyVec & ~clrMask) | setMask;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busyVec <= '0;
        else     busyVec <= busyNext;
    end

    function automatic logic isBusy(input regIdx_t idx);
        return (idx != '0) && busyVec[idx];
    endfunction

`ifdef WB_BYPASS_EN
    // The value being written this cycle is forwarded, so the source operand is free.
    function automatic logic fwdHit(input regIdx_t idx);
        return clrVld && (idx == clrIdx);
    endfunction

    assign rs1Busy = isBusy(rs1Idx) && !fwdHit(rs1Idx);
    assign rs2Busy = isBusy(rs2Idx) && !fwdHit(rs2Idx);
`else
    assign rs1Busy = isBusy(rs1Idx);
    assign rs2Busy = isBusy(rs2Idx);
`endif
    assign rdBusy = isBusy(rdIdx);

endmodule

// File: rtl/ysyx_22041412_wb_arb.sv
// Purpose: writeback arbiter (ALU > LSU > MDU with starvation promotion) driving the GPR write port.
// Latency: handshake in cycle T -> registered rf_wen/rf_rd/rf_wdata in T+1.
// Backpressure: *_ready is the combinational grant; at most one source accepted per cycle.
// Ports: clk, rst (sync, active-high); iss_valid/iss_rd; alu/lsu/mdu result channels (slave);
//        rf_wen/rf_rd/rf_wdata; rs1/rs2/rd -> rs1_busy/rs2_busy/rd_busy.
// Option WB_BYPASS_EN: adds rs1_fwd/rs2_fwd carrying rf_wdata when rsN matches the write.
module ysyx_22041412_wb_arb
    import ysyx_22041412_wb_arb_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_valid,
    input  regIdx_t                      iss_rd,
    ysyx_22041412_wb_arb_if.slave        alu,
    ysyx_22041412_wb_arb_if.slave        lsu,
    ysyx_22041412_wb_arb_if.slave        mdu,
    output logic                         rf_wen,
    output regIdx_t                      rf_rd,
    output xlen_t                        rf_wdata,
    input  regIdx_t                      rs1,
    input  regIdx_t                      rs2,
    input  regIdx_t                      rd,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic                         rd_busy
`ifdef WB_BYPASS_EN
    ,
    output xlen_t                        rs1_fwd,
    output xlen_t                        rs2_fwd
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(STARVE_LIM);

    cnt_t    lsuCnt;
    cnt_t    mduCnt;
    src_e    grant;
    regIdx_t selRd;
    xlen_t   selData;
    logic    wrReal;

    // Only the two lower-priority sources can starve, so only they carry counters.
    wire lsuSat = lsu.valid && (lsuCnt == CNT_MAX);
    wire mduSat = mdu.valid && (mduCnt == CNT_MAX);

    always_comb begin
        grant = SRC_NONE;
        if (!rst) begin
            if      (lsuSat)    grant = SRC_LSU;
            else if (mduSat)    grant = SRC_MDU;
            else if (alu.valid) grant = SRC_ALU;
            else if (lsu.valid) grant = SRC_LSU;
            else if (mdu.valid) grant = SRC_MDU;
        end
    end

    assign alu.ready = (grant == SRC_ALU);
    assign lsu.ready = (grant == SRC_LSU);
    assign mdu.ready = (grant == SRC_MDU);

    always_comb begin
        selRd   = '0;
        selData = '0;
        case (grant)
            SRC_ALU: begin selRd = alu.rd; selData = alu.data; end
            SRC_LSU: begin selRd = lsu.rd; selData = lsu.data; end
            SRC_MDU: begin selRd = mdu.rd; selData = mdu.data; end
            default: ;
        endcase
    end

    // x0 results complete the handshake but never reach the register file.
    assign wrReal = (grant != SRC_NONE) && (selRd != '0);

    // Counter clears whenever the source is idle or served, so dropping valid resets it.
    function automatic cnt_t cntNext(input logic v, input logic r, input cnt_t c);
        if (!v || r)          return '0;
        else if (c == CNT_MAX) return c;
        else                   return c + cnt_t'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            lsuCnt <= '0;
            mduCnt <= '0;
        end else begin
            lsuCnt <= cntNext(lsu.valid, lsu.ready, lsuCnt);
            mduCnt <= cntNext(mdu.valid, mdu.ready, mduCnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= wrReal;
            if (wrReal) begin
                rf_rd    <= selRd;
                rf_wdata <= selData;
            end
        end
    end

    ysyx_22041412_wb_arb_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .setVld  (iss_valid),
        .setIdx  (iss_rd),
        .clrVld  (rf_wen),
        .clrIdx  (rf_rd),
        .rs1Idx  (rs1),
        .rs2Idx  (rs2),
        .rdIdx   (rd),
        .rs1Busy (rs1_busy),
        .rs2Busy (rs2_busy),
        .rdBusy  (rd_busy)
    );

`ifdef WB_BYPASS_EN
    assign rs1_fwd = (rf_wen && rs1 == rf_rd) ? rf_wdata : '0;
    assign rs2_fwd = (rf_wen && rs2 == rf_rd) ? rf_wdata : '0;
`endif

endmodule
